i2c_adc_responder: RTL and testbench

- I2C target that emulates the 4-register ADS1115-style ADC map our adc/i2c initiator pair talks to.
- Used as a hardware-in-loop stand-in on a spare SCL/SDA pin pair, so the controller loop can be exercised with synthetic samples and no real converter.
- Responds to address writes (pointer, config) and reads (conversion, config, thresholds).
- Runs a configurable conversion timer triggered by the config OS bit.

---
 rtl/i2c_adc_responder_pkg.sv | 25 ++
 rtl/i2c_bus_monitor.sv | 48 ++++
 rtl/i2c_adc_responder.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_adc_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_adc_responder_pkg.sv
// Shared constants and types for the ADS1115-style I2C ADC responder.
// Register pointer codes, register reset values and the responder FSM encoding.
package i2c_adc_responder_pkg;

  localparam logic [1:0] PTR_CONV = 2'd0;
  localparam logic [1:0] PTR_CFG  = 2'd1;
  localparam logic [1:0] PTR_LO   = 2'd2;
  localparam logic [1:0] PTR_HI   = 2'd3;

  localparam logic [15:0] CFG_RESET       = 16'h8583;
  localparam logic [15:0] LO_THRESH_RESET = 16'h8000;
  localparam logic [15:0] HI_THRESH_RESET = 16'h7FFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX_BYTE  = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX_BYTE  = 3'd5,
    ST_TX_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA into clk_i and derives one-cycle bus event strobes.
// START/STOP are SDA edges seen while SCL is high on both the current and the previous sample.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_prev_r;
  logic                   sda_prev_r;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_s = sda_sync_r[SYNC_STAGES-1];

  // Synchroniser chains plus one delayed copy for edge detection; the bus idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_r <= '1;
      sda_sync_r <= '1;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_r;
  assign scl_fall_o = ~scl_s & scl_prev_r;
  assign start_o    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_o     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;

endmodule

// File: rtl/i2c_adc_responder.sv
// I2C target emulating a 4-register ADS1115-style ADC, with a timed synthetic conversion.
// SDA is only ever changed on the cycle after a detected SCL fall, so the responder never forms a START/STOP itself.
module i2c_adc_responder
  import i2c_adc_responder_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'b1001001,
  parameter int         CONV_CYCLES = 31395,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic [15:0] sample_i,
  output logic [15:0] config_o,
  output logic        conv_start_o,
  output logic        busy_o,
  output logic        active_o
);

  localparam int            TW         = $clog2(CONV_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CONV_CYCLES - 1);

  logic          sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  state_e        state_r, state_next_s;
  logic [3:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          ack_r;
  logic [1:0]    byte_idx_r;
  logic [1:0]    pointer_r;
  logic [7:0]    stage_r;
  logic [15:0]   tx_word_r;
  logic          byte_sel_r;
  logic [15:0]   config_r;
  logic [15:0]   conv_r;
  logic          busy_r;
  logic [TW-1:0] timer_r;
  logic          conv_start_r;
  logic          sda_oe_r, oe_next_s;
  logic          active_r, active_next_s;
  logic          byte_done_s, addr_match_s, rx_byte_end_s, snapshot_s, wr_commit_s;
  logic [15:0]   rd_word_s;
  logic [7:0]    tx_byte_s;
  logic [2:0]    tx_idx_s;

  i2c_bus_monitor #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_monitor (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise_s),
    .scl_fall_o (scl_fall_s),
    .start_o    (start_s),
    .stop_o     (stop_s)
  );

  assign byte_done_s   = scl_fall_s && (bit_cnt_r == 4'd8);
  assign addr_match_s  = (shift_r[7:1] == ADDRESS);
  assign rx_byte_end_s = (state_r == ST_RX_BYTE) && (state_next_s == ST_RX_ACK);
  assign snapshot_s    = (state_r == ST_ADDR) && (state_next_s == ST_ADDR_ACK);
  assign wr_commit_s   = rx_byte_end_s && (byte_idx_r == 2'd2) && (pointer_r == PTR_CFG);
  assign tx_byte_s     = byte_sel_r ? tx_word_r[7:0] : tx_word_r[15:8];
  assign tx_idx_s      = (state_r == ST_TX_BYTE) ? (3'd7 - bit_cnt_r[2:0]) : 3'd7;

  // Read mux selected by the pointer; OS reads back as "not busy".
  always_comb begin
    case (pointer_r)
      PTR_CONV: rd_word_s = conv_r;
      PTR_CFG:  rd_word_s = {~busy_r, config_r[14:0]};
      PTR_LO:   rd_word_s = LO_THRESH_RESET;
      PTR_HI:   rd_word_s = HI_THRESH_RESET;
      default:  rd_word_s = conv_r;
    endcase
  end

  // State register and registered bus outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      sda_oe_r <= 1'b0;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      sda_oe_r <= oe_next_s;
      active_r <= active_next_s;
    end
  end

  // Next-state logic; STOP then START override any bit activity.
  always_comb begin
    state_next_s = state_r;
    if (stop_s) begin
      state_next_s = ST_IDLE;
    end else if (start_s) begin
      state_next_s = ST_ADDR;
    end else begin
      case (state_r)
        ST_ADDR:     state_next_s = byte_done_s ? (addr_match_s ? ST_ADDR_ACK : ST_IGNORE) : ST_ADDR;
        ST_ADDR_ACK: state_next_s = scl_fall_s ? (shift_r[0] ? ST_TX_BYTE : ST_RX_BYTE) : ST_ADDR_ACK;
        ST_RX_BYTE:  state_next_s = byte_done_s ? ST_RX_ACK : ST_RX_BYTE;
        ST_RX_ACK:   state_next_s = scl_fall_s ? ST_RX_BYTE : ST_RX_ACK;
        ST_TX_BYTE:  state_next_s = byte_done_s ? ST_TX_ACK : ST_TX_BYTE;
        ST_TX_ACK:   state_next_s = scl_fall_s ? (ack_r ? ST_IGNORE : ST_TX_BYTE) : ST_TX_ACK;
        default:     state_next_s = state_r;
      endcase
    end
  end

  // Output logic: SDA drive is re-evaluated only on SCL fall, from the state being entered.
  always_comb begin
    oe_next_s     = sda_oe_r;
    active_next_s = active_r;
    if (start_s || stop_s) begin
      oe_next_s     = 1'b0;
      active_next_s = 1'b0;
    end else begin
      active_next_s = (state_next_s == ST_ADDR_ACK) ? 1'b1 : active_r;
      if (scl_fall_s) begin
        case (state_next_s)
          ST_ADDR_ACK, ST_RX_ACK: oe_next_s = 1'b1;
          ST_TX_BYTE:             oe_next_s = ~tx_byte_s[tx_idx_s];
          default:                oe_next_s = 1'b0;
        endcase
      end else begin
        oe_next_s = sda_oe_r;
      end
    end
  end

  // Bit/byte datapath: shifter, byte index, pointer, staging and read snapshot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      ack_r      <= 1'b1;
      byte_idx_r <= 2'd0;
      pointer_r  <= PTR_CONV;
      stage_r    <= 8'h00;
      tx_word_r  <= 16'h0000;
      byte_sel_r <= 1'b0;
    end else begin
      if (start_s || (state_next_s != state_r)) begin
        bit_cnt_r <= 4'd0;
      end else if (scl_rise_s && (state_r == ST_ADDR || state_r == ST_RX_BYTE || state_r == ST_TX_BYTE)) begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end
      if (scl_rise_s && (state_r == ST_ADDR || state_r == ST_RX_BYTE)) begin
        shift_r <= {shift_r[6:0], sda_s};
      end
      if (scl_rise_s && (state_r == ST_TX_ACK)) begin
        ack_r <= sda_s;
      end
      if (state_r == ST_ADDR_ACK) begin
        byte_idx_r <= 2'd0;
      end else if (rx_byte_end_s && (byte_idx_r != 2'd3)) begin
        byte_idx_r <= byte_idx_r + 2'd1;
      end
      if (rx_byte_end_s && (byte_idx_r == 2'd0)) begin
        pointer_r <= shift_r[1:0];
      end
      if (rx_byte_end_s && (byte_idx_r == 2'd1)) begin
        stage_r <= shift_r;
      end
      // The snapshot keeps a multi-byte read coherent across a conversion completing.
      if (snapshot_s) begin
        tx_word_r  <= rd_word_s;
        byte_sel_r <= 1'b0;
      end else if ((state_r == ST_TX_BYTE) && (state_next_s == ST_TX_ACK)) begin
        byte_sel_r <= ~byte_sel_r;
      end
    end
  end

  // Config commit and conversion timer; an OS request while busy is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      config_r     <= CFG_RESET;
      conv_r       <= 16'h0000;
      busy_r       <= 1'b0;
      timer_r      <= '0;
      conv_start_r <= 1'b0;
    end else begin
      conv_start_r <= 1'b0;
      if (wr_commit_s) begin
        config_r <= {1'b0, stage_r[6:0], shift_r};
      end
      if (busy_r) begin
        if (timer_r == '0) begin
          conv_r <= sample_i;
          busy_r <= 1'b0;
        end else begin
          timer_r <= timer_r - TW'(1);
        end
      end else if (wr_commit_s && stage_r[7]) begin
        conv_start_r <= 1'b1;
        busy_r       <= 1'b1;
        timer_r      <= TIMER_LOAD;
      end
    end
  end

  assign sda_oe_o     = sda_oe_r;
  assign active_o     = active_r;
  assign config_o     = config_r;
  assign busy_o       = busy_r;
  assign conv_start_o = conv_start_r;

endmodule

// File: tb/tb_i2c_adc_responder.sv
// Bench for i2c_adc_responder: bit-banged I2C controller on an open-drain SDA model,
// expected read bytes queued when a read is issued and compared as the bytes arrive.
module tb_i2c_adc_responder;

  localparam int CONV = 2000;
  localparam int Q    = 10;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        scl = 1'b1;
  logic        sda_drv_low = 1'b0;
  logic        sda_line;
  logic        sda_oe_o;
  logic [15:0] sample_i = 16'h0000;
  logic [15:0] config_o;
  logic        conv_start_o, busy_o, active_o;

  int n_checks = 0;
  int n_err = 0;
  int busy_cycles = 0, start_pulses = 0, oe_cycles = 0, active_cycles = 0;
  logic [7:0] exp_q[$];

  assign sda_line = ~(sda_drv_low | sda_oe_o);

  i2c_adc_responder #(
    .ADDRESS     (7'b1001001),
    .CONV_CYCLES (CONV),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .scl_i        (scl),
    .sda_i        (sda_line),
    .sda_oe_o     (sda_oe_o),
    .sample_i     (sample_i),
    .config_o     (config_o),
    .conv_start_o (conv_start_o),
    .busy_o       (busy_o),
    .active_o     (active_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (busy_o) busy_cycles++;
    if (conv_start_o) start_pulses++;
    if (sda_oe_o) oe_cycles++;
    if (active_o) active_cycles++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
  endtask

  task automatic i2c_start();
    sda_drv_low = 1'b0; scl = 1'b1; tick(Q);
    sda_drv_low = 1'b1; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_rstart();
    sda_drv_low = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    sda_drv_low = 1'b1; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_drv_low = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    sda_drv_low = 1'b0; tick(2 * Q);
  endtask

  task automatic put_bit(input logic b);
    sda_drv_low = ~b; tick(Q);
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_drv_low = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    @(negedge clk_i);
    b = sda_line;
    tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic wr(input logic [7:0] b, input logic ack_exp, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    check_eq(tag, 16'(a), 16'(ack_exp));
  endtask

  task automatic expect_word(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic read_expect(input int n);
    logic [7:0] d;
    logic [7:0] e;
    logic       b;
    for (int i = 0; i < n; i++) begin
      d = 8'h00;
      for (int k = 7; k >= 0; k--) begin
        get_bit(b);
        d[k] = b;
      end
      put_bit(i == n - 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check_eq("rd_byte", 16'(d), 16'(e));
    end
  endtask

  task automatic read_ptr(input logic [1:0] p, input logic [15:0] w);
    i2c_start();
    wr(8'h92, 1'b0, "ack_aw");
    wr({6'b000000, p}, 1'b0, "ack_ptr");
    i2c_rstart();
    wr(8'h93, 1'b0, "ack_ar");
    expect_word(w);
    read_expect(2);
    i2c_stop();
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < 3 * CONV && busy_o; i++) @(posedge clk_i);
    #1;
    check_eq("busy_done", 16'(busy_o), 16'h0000);
  endtask

  initial begin
    int b0, s0, o0, a0;
    logic bit_v;
    tick(5);
    #1;
    check_eq("rst_oe", 16'(sda_oe_o), 16'h0000);
    check_eq("rst_active", 16'(active_o), 16'h0000);
    check_eq("rst_busy", 16'(busy_o), 16'h0000);
    check_eq("rst_cstart", 16'(conv_start_o), 16'h0000);
    check_eq("rst_config", config_o, 16'h8583);
    rst_ni = 1'b1;
    tick(5);

    // Repeated START read of the conversion register, then the other pointers
    i2c_start();
    wr(8'h92, 1'b0, "ack_aw");
    wr(8'h00, 1'b0, "ack_ptr");
    i2c_rstart();
    wr(8'h93, 1'b0, "ack_ar");
    #1 check_eq("active_rd", 16'(active_o), 16'h0001);
    expect_word(16'h0000);
    read_expect(2);
    i2c_stop();
    #1 check_eq("active_stop", 16'(active_o), 16'h0000);
    read_ptr(2'd1, 16'h8583);
    read_ptr(2'd2, 16'h8000);
    read_ptr(2'd3, 16'h7FFF);

    // Wrong address: never ACKed, never active
    o0 = oe_cycles; a0 = active_cycles; s0 = start_pulses;
    i2c_start();
    wr(8'h90, 1'b1, "nack_addr");
    wr(8'h01, 1'b1, "nack_d0");
    wr(8'hC3, 1'b1, "nack_d1");
    wr(8'h83, 1'b1, "nack_d2");
    i2c_stop();
    check_eq("mis_oe", 16'(oe_cycles - o0), 16'h0000);
    check_eq("mis_active", 16'(active_cycles - a0), 16'h0000);
    check_eq("mis_config", config_o, 16'h8583);
    check_eq("mis_cstart", 16'(start_pulses - s0), 16'h0000);

    // STOP after the MSB byte discards the staged data
    i2c_start();
    wr(8'h92, 1'b0, "ack_aw");
    wr(8'h01, 1'b0, "ack_ptr");
    wr(8'hAA, 1'b0, "ack_msb");
    i2c_stop();
    check_eq("abort_config", config_o, 16'h8583);
    check_eq("abort_cstart", 16'(start_pulses - s0), 16'h0000);

    // Conversion start, config read while busy and after completion
    sample_i = 16'h1234;
    b0 = busy_cycles; s0 = start_pulses;
    i2c_start();
    wr(8'h92, 1'b0, "ack_aw");
    wr(8'h01, 1'b0, "ack_ptr");
    wr(8'hC3, 1'b0, "ack_msb");
    wr(8'h83, 1'b0, "ack_lsb");
    i2c_rstart();
    wr(8'h93, 1'b0, "ack_ar");
    expect_word(16'h4383);
    read_expect(2);
    i2c_stop();
    #1;
    check_eq("busy_mid", 16'(busy_o), 16'h0001);
    check_eq("config_os0", config_o, 16'h4383);
    wait_not_busy();
    check_eq("busy_len", 16'(busy_cycles - b0), 16'(CONV));
    check_eq("cstart_once", 16'(start_pulses - s0), 16'h0001);
    i2c_start();
    wr(8'h93, 1'b0, "ack_ar");
    expect_word(16'hC383);
    read_expect(2);
    i2c_stop();
    read_ptr(2'd0, 16'h1234);

    // Conversion completes during a 5-byte read: snapshot must not tear
    sample_i = 16'h5678;
    s0 = start_pulses;
    i2c_start();
    wr(8'h92, 1'b0, "ack_aw");
    wr(8'h01, 1'b0, "ack_ptr");
    wr(8'hC3, 1'b0, "ack_msb");
    wr(8'h83, 1'b0, "ack_lsb");
    i2c_rstart();
    wr(8'h92, 1'b0, "ack_aw");
    wr(8'h00, 1'b0, "ack_ptr");
    i2c_rstart();
    wr(8'h93, 1'b0, "ack_ar");
    #1 check_eq("busy_snap", 16'(busy_o), 16'h0001);
    expect_word(16'h1234);
    expect_word(16'h1234);
    exp_q.push_back(8'h12);
    read_expect(5);
    i2c_stop();
    #1 check_eq("busy_after", 16'(busy_o), 16'h0000);
    check_eq("cstart_two", 16'(start_pulses - s0), 16'h0001);
    read_ptr(2'd0, 16'h5678);

    // Reset asserted while the responder is driving SDA low in a read
    i2c_start();
    wr(8'h92, 1'b0, "ack_aw");
    wr(8'h01, 1'b0, "ack_ptr");
    i2c_rstart();
    wr(8'h93, 1'b0, "ack_ar");
    for (int i = 0; i < 3; i++) get_bit(bit_v);
    check_eq("pre_rst_oe", 16'(sda_oe_o), 16'h0001);
    rst_ni = 1'b0;
    #1;
    check_eq("rst_mid_oe", 16'(sda_oe_o), 16'h0000);
    check_eq("rst_mid_active", 16'(active_o), 16'h0000);
    check_eq("rst_mid_config", config_o, 16'h8583);
    sda_drv_low = 1'b0;
    scl = 1'b1;
    tick(5);
    rst_ni = 1'b1;
    tick(5);
    read_ptr(2'd1, 16'h8583);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
